// File: rtl/signature_compactor.sv
// signature_compactor
//   Self-test signature engine. A stimulus counter drives the DUT input pins
//   while NUM_CH observation buses plus a seed are XOR-folded each cycle into
//   a rotate-add accumulator. A run is launched by start from IDLE or DONE,
//   lasts 2^CNT_W-1 accumulate cycles, then parks in DONE until re-armed.
//
//   Optional feature macro: SIGCMP_EN (adds expected/pass/fail comparison).
//
// Ports:
//   clk        in   1          system clock, rising edge
//   reset      in   1          asynchronous, active-low reset
//   start      in   1          launches a run when sampled in IDLE or DONE
//   seed       in   W          XORed into the fold every cycle
//   ch_data    in   NUM_CH*W   observation channels, channel k at [k*W +: W]
//   expected   in   2*W        reference signature (SIGCMP_EN only)
//   stimulus   out  CNT_W      stimulus counter to the DUT
//   busy       out  1          high while running
//   done       out  1          high while in DONE
//   signature  out  2*W        accumulator value
//   pass       out  1          signature matched expected (SIGCMP_EN only)
//   fail       out  1          signature differed from expected (SIGCMP_EN only)

module signature_compactor #(
    parameter int unsigned W      = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [W-1:0]        seed,
    input  logic [NUM_CH*W-1:0] ch_data,
`ifdef SIGCMP_EN
    input  logic [2*W-1:0]      expected,
    output logic                pass,
    output logic                fail,
`endif
    output logic [CNT_W-1:0]    stimulus,
    output logic                busy,
    output logic                done,
    output logic [2*W-1:0]      signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   fold;
    logic [W-1:0]   sum;
    logic [2*W-1:0] next_sig;

    // Lower half absorbs the fold; the whole word then rotates left by one,
    // so the top bit wraps into bit 0 and the sum lands in [W:1].
    always_comb begin
        fold = seed;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            fold = fold ^ ch_data[k*W +: W];
        end
        sum      = signature[W-1:0] + fold;
        next_sig = {signature[2*W-2:W], sum, signature[2*W-1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stimulus  <= '0;
            signature <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SIGCMP_EN
            pass      <= 1'b0;
            fail      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        stimulus  <= '0;
                        signature <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef SIGCMP_EN
                        pass      <= 1'b0;
                        fail      <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (stimulus != '1) begin
                        signature <= next_sig;
                        stimulus  <= stimulus + CNT_W'(1);
                    end else begin
                        // Counter full: no accumulate, stimulus saturates.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef SIGCMP_EN
                        pass  <= (signature == expected);
                        fail  <= (signature != expected);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signature_compactor.sv
module tb_signature_compactor;

    logic clk;
    logic reset;

    int total;
    int bad;

    // Instance A: W=8, NUM_CH=1, CNT_W=2
    logic        a_start;
    logic [7:0]  a_seed;
    logic [7:0]  a_ch;
    logic [1:0]  a_stim;
    logic        a_busy;
    logic        a_done;
    logic [15:0] a_sig;
`ifdef SIGCMP_EN
    logic [15:0] a_exp;
    logic        a_pass;
    logic        a_fail;
    logic [15:0] b_exp;
    logic        b_pass;
    logic        b_fail;
    logic [15:0] c_exp;
    logic        c_pass;
    logic        c_fail;
`endif

    // Instance B: W=8, NUM_CH=4, CNT_W=2
    logic        b_start;
    logic [7:0]  b_seed;
    logic [31:0] b_ch;
    logic [1:0]  b_stim;
    logic        b_busy;
    logic        b_done;
    logic [15:0] b_sig;

    // Instance C: default parameters
    logic        c_start;
    logic [7:0]  c_seed;
    logic [31:0] c_ch;
    logic [7:0]  c_stim;
    logic        c_busy;
    logic        c_done;
    logic [15:0] c_sig;

    signature_compactor #(.W(8), .NUM_CH(1), .CNT_W(2)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .seed(a_seed), .ch_data(a_ch),
`ifdef SIGCMP_EN
        .expected(a_exp), .pass(a_pass), .fail(a_fail),
`endif
        .stimulus(a_stim), .busy(a_busy), .done(a_done), .signature(a_sig)
    );

    signature_compactor #(.W(8), .NUM_CH(4), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .seed(b_seed), .ch_data(b_ch),
`ifdef SIGCMP_EN
        .expected(b_exp), .pass(b_pass), .fail(b_fail),
`endif
        .stimulus(b_stim), .busy(b_busy), .done(b_done), .signature(b_sig)
    );

    signature_compactor #(.W(8), .NUM_CH(4), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .seed(c_seed), .ch_data(c_ch),
`ifdef SIGCMP_EN
        .expected(c_exp), .pass(c_pass), .fail(c_fail),
`endif
        .stimulus(c_stim), .busy(c_busy), .done(c_done), .signature(c_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a run on instance A and check the three accumulate steps.
    task automatic run_a(input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] s3);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_launch_busy", 32'(a_busy), 32'd1);
        check("a_launch_done", 32'(a_done), 32'd0);
        check("a_launch_stim", 32'(a_stim), 32'd0);
        check("a_launch_sig",  32'(a_sig),  32'd0);
`ifdef SIGCMP_EN
        check("a_launch_pass", 32'(a_pass), 32'd0);
        check("a_launch_fail", 32'(a_fail), 32'd0);
`endif
        tick();
        check("a_step1", 32'(a_sig), 32'(s1));
        tick();
        check("a_step2", 32'(a_sig), 32'(s2));
        tick();
        check("a_step3", 32'(a_sig), 32'(s3));
        check("a_step3_busy", 32'(a_busy), 32'd1);
        check("a_step3_stim", 32'(a_stim), 32'd3);
        tick();
        check("a_done",      32'(a_done), 32'd1);
        check("a_done_busy", 32'(a_busy), 32'd0);
        check("a_done_sig",  32'(a_sig),  32'(s3));
        check("a_done_stim", 32'(a_stim), 32'd3);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a_start = 1'b0; a_seed = 8'h00; a_ch = 8'h00;
        b_start = 1'b0; b_seed = 8'h00; b_ch = 32'h0;
        c_start = 1'b0; c_seed = 8'h00; c_ch = 32'h0;
`ifdef SIGCMP_EN
        a_exp = 16'h0; b_exp = 16'h0; c_exp = 16'h0;
`endif
        #2 reset = 1'b0;
        #1;
        check("rst_stim", 32'(a_stim), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_sig",  32'(a_sig),  32'd0);
        #20 reset = 1'b1;
        tick();

        // Zero fold: signature stays zero.
        run_a(16'h0000, 16'h0000, 16'h0000);

        // Done holds while start stays low.
        tick();
        tick();
        check("a_hold_done", 32'(a_done), 32'd1);
        check("a_hold_sig",  32'(a_sig),  32'd0);

        // LSB growth, re-armed from DONE.
        a_seed = 8'h01;
`ifdef SIGCMP_EN
        a_exp = 16'h000E;
`endif
        run_a(16'h0002, 16'h0006, 16'h000E);
`ifdef SIGCMP_EN
        check("cmp_match_pass", 32'(a_pass), 32'd1);
        check("cmp_match_fail", 32'(a_fail), 32'd0);
        a_exp = 16'h000F;
        run_a(16'h0002, 16'h0006, 16'h000E);
        check("cmp_miss_pass", 32'(a_pass), 32'd0);
        check("cmp_miss_fail", 32'(a_fail), 32'd1);
`endif

        // Rotation across the two halves.
        a_seed = 8'h80;
        run_a(16'h0100, 16'h0300, 16'h0700);

        // Multi-channel fold 0F, with a start pulse mid-run that must be ignored.
        b_ch = 32'h08040201;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_launch_busy", 32'(b_busy), 32'd1);
        tick();
        check("b_step1", 32'(b_sig), 32'h001E);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_step2",      32'(b_sig),  32'h005A);
        check("b_step2_stim", 32'(b_stim), 32'd2);
        tick();
        check("b_step3",      32'(b_sig),  32'h00D2);
        check("b_step3_busy", 32'(b_busy), 32'd1);
        tick();
        check("b_done",     32'(b_done), 32'd1);
        check("b_done_sig", 32'(b_sig),  32'h00D2);

        // Default config: reset aborts a run at stimulus 0x40.
        c_seed = 8'h01;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        n = 0;
        while (c_stim != 8'h40 && n < 200) begin
            tick();
            n++;
        end
        check("c_reach_40", 32'(n), 32'd64);
        reset = 1'b0;
        #1;
        check("c_abort_stim", 32'(c_stim), 32'd0);
        check("c_abort_busy", 32'(c_busy), 32'd0);
        check("c_abort_done", 32'(c_done), 32'd0);
        check("c_abort_sig",  32'(c_sig),  32'd0);
        #2 reset = 1'b1;
        tick();
        check("c_idle_busy", 32'(c_busy), 32'd0);
        check("c_idle_done", 32'(c_done), 32'd0);

        // Full default run: done 256 edges after the start edge.
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        n = 0;
        while (!c_done && n < 400) begin
            tick();
            n++;
        end
        check("c_run_len",    32'(n),      32'd256);
        check("c_full_stim",  32'(c_stim), 32'hFF);
        check("c_full_sig_nz", 32'(c_sig != 16'h0), 32'd1);

        // Re-arm from DONE.
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        check("c_rearm_done", 32'(c_done), 32'd0);
        check("c_rearm_busy", 32'(c_busy), 32'd1);
        check("c_rearm_stim", 32'(c_stim), 32'd0);
        check("c_rearm_sig",  32'(c_sig),  32'd0);
        tick();
        check("c_rearm_step1", 32'(c_sig), 32'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
